// File: rtl/echo_indication_input.sv
// echo_indication_input: decodes packed heard messages from the transport pipe into a FIFO replayed to indication_heard
module echo_indication_input #(
  parameter logic [31:0] HEARD_ID = 32'd1,
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pipe_enq__ENA,
  input  logic [95:0] pipe_enq_v,
  output logic        pipe_enq__RDY,
  output logic        indication_heard__ENA,
  output logic [31:0] indication_heard_meth,
  output logic [31:0] indication_heard_v,
  input  logic        indication_heard__RDY,
  output logic [15:0] unknown_count,
  output logic [31:0] last_unknown_id
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [63:0] mem [DEPTH];
  logic enq, hit, deq;
  assign pipe_enq__RDY = !RST && cnt != (AW+1)'(DEPTH);
  assign enq = pipe_enq__ENA && pipe_enq__RDY;
  assign hit = enq && pipe_enq_v[31:0] == HEARD_ID;
  assign deq = indication_heard__ENA && indication_heard__RDY;
  assign indication_heard__ENA = cnt != '0;
  assign indication_heard_meth = mem[rp][31:0];
  assign indication_heard_v = mem[rp][63:32];
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      unknown_count <= '0;
      last_unknown_id <= '0;
    end else begin
      wp <= wp + AW'(hit);
      rp <= rp + AW'(deq);
      cnt <= cnt + (AW+1)'(hit) - (AW+1)'(deq);
      if (enq && !hit) begin
        unknown_count <= unknown_count == 16'hFFFF ? unknown_count : unknown_count + 16'd1;
        last_unknown_id <= pipe_enq_v[31:0];
      end
    end
  end
  always_ff @(posedge CLK)
    if (hit) mem[wp] <= pipe_enq_v[95:32];
endmodule

// File: tb/tb_echo_indication_input.sv
// tb_echo_indication_input: scoreboard bench; sends push expected calls, a negedge monitor pops and compares deliveries
module tb_echo_indication_input;
  logic        CLK = 0;
  logic        RST;
  logic        pipe_enq__ENA;
  logic [95:0] pipe_enq_v;
  logic        pipe_enq__RDY;
  logic        indication_heard__ENA;
  logic [31:0] indication_heard_meth;
  logic [31:0] indication_heard_v;
  logic        indication_heard__RDY;
  logic [15:0] unknown_count;
  logic [31:0] last_unknown_id;
  int n_tests = 0, n_fail = 0, n_deliv = 0;
  logic [63:0] sb [$];

  echo_indication_input dut (
    .CLK(CLK), .RST(RST),
    .pipe_enq__ENA(pipe_enq__ENA), .pipe_enq_v(pipe_enq_v), .pipe_enq__RDY(pipe_enq__RDY),
    .indication_heard__ENA(indication_heard__ENA), .indication_heard_meth(indication_heard_meth),
    .indication_heard_v(indication_heard_v), .indication_heard__RDY(indication_heard__RDY),
    .unknown_count(unknown_count), .last_unknown_id(last_unknown_id)
  );

  always #5 CLK = ~CLK;

  // a handshake seen at negedge completes at the following rising edge
  always @(negedge CLK) begin
    if (!RST && indication_heard__ENA && indication_heard__RDY) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL deliver: got meth=%h v=%h, expected no call", indication_heard_meth, indication_heard_v);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({indication_heard_v, indication_heard_meth} !== e) begin
          n_fail++;
          $display("FAIL deliver: got v=%h meth=%h, expected v=%h meth=%h",
                   indication_heard_v, indication_heard_meth, e[63:32], e[31:0]);
        end
        n_deliv++;
      end
    end
  end

  task automatic send(input logic [31:0] id, input logic [31:0] m, input logic [31:0] vv);
    int k = 0;
    pipe_enq__ENA = 1;
    pipe_enq_v = {vv, m, id};
    @(negedge CLK);
    while (!pipe_enq__RDY && k < 200) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      k++;
    end
    n_tests++;
    if (!pipe_enq__RDY) begin
      n_fail++;
      $display("FAIL send_timeout: enq RDY=%b after %0d cycles, expected 1", pipe_enq__RDY, k);
      @(posedge CLK); #1;
      pipe_enq__ENA = 0;
      return;
    end
    if (id == 32'd1) sb.push_back({vv, m});
    @(posedge CLK); #1;
    pipe_enq__ENA = 0;
  endtask

  task automatic do_reset();
    RST = 1;
    sb.delete();
    @(posedge CLK); #1;
    RST = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge CLK);
    @(negedge CLK);
    n_tests++;
    if (sb.size() != 0 || indication_heard__ENA !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d ENA=%b, expected 0 and 0", sb.size(), indication_heard__ENA);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    n_tests++;
    if ({pipe_enq__RDY, indication_heard__ENA} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: enqRDY=%b ENA=%b, expected 0 0", pipe_enq__RDY, indication_heard__ENA);
    end
    n_tests++;
    if (unknown_count !== 16'd0 || last_unknown_id !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: count=%h last=%h, expected 0 0", unknown_count, last_unknown_id);
    end
    @(posedge CLK); #1;
    RST = 0;
    @(negedge CLK);
    n_tests++;
    if (pipe_enq__RDY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: enqRDY=%b, expected 1", pipe_enq__RDY);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_single();
    int d0 = n_deliv;
    indication_heard__RDY = 1;
    send(32'd1, 32'h5, 32'hDEADBEEF);
    @(negedge CLK);
    n_tests++;
    if ({indication_heard__ENA, indication_heard_meth, indication_heard_v} !== {1'b1, 32'h5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL single_latency: ENA=%b meth=%h v=%h, expected 1 5 deadbeef",
               indication_heard__ENA, indication_heard_meth, indication_heard_v);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    n_tests++;
    if (indication_heard__ENA !== 1'b0 || n_deliv - d0 != 1) begin
      n_fail++;
      $display("FAIL single_once: ENA=%b delivered=%0d, expected 0 1", indication_heard__ENA, n_deliv - d0);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_backpressure();
    indication_heard__RDY = 0;
    send(32'd1, 32'hA1, 32'd1);
    send(32'd1, 32'hA2, 32'd2);
    @(negedge CLK);
    n_tests++;
    if ({pipe_enq__RDY, indication_heard__ENA, indication_heard_v} !== {1'b0, 1'b1, 32'd1}) begin
      n_fail++;
      $display("FAIL bp_full: enqRDY=%b ENA=%b v=%h, expected 0 1 1",
               pipe_enq__RDY, indication_heard__ENA, indication_heard_v);
    end
    @(posedge CLK); #1;
    fork
      send(32'd1, 32'hA3, 32'd3);
      begin
        repeat (3) begin
          @(negedge CLK);
          n_tests++;
          if (pipe_enq__RDY !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: enqRDY=%b while full, expected 0", pipe_enq__RDY);
          end
        end
        @(posedge CLK); #1;
        indication_heard__RDY = 1;
      end
    join
    drain();
  endtask

  task automatic test_unknown();
    do_reset();
    indication_heard__RDY = 0;
    send(32'd7, 32'h77, 32'h77);
    send(32'd1, 32'hB1, 32'd9);
    send(32'd1, 32'hB2, 32'd10);
    @(negedge CLK);
    n_tests++;
    if (unknown_count !== 16'd1 || last_unknown_id !== 32'd7) begin
      n_fail++;
      $display("FAIL unknown_count: count=%h last=%h, expected 1 7", unknown_count, last_unknown_id);
    end
    n_tests++;
    if (pipe_enq__RDY !== 1'b0 || indication_heard_v !== 32'd9) begin
      n_fail++;
      $display("FAIL unknown_slot: enqRDY=%b head v=%h, expected 0 9", pipe_enq__RDY, indication_heard_v);
    end
    @(posedge CLK); #1;
    indication_heard__RDY = 1;
    drain();
  endtask

  task automatic test_saturation();
    do_reset();
    pipe_enq__ENA = 1;
    pipe_enq_v = {32'h0, 32'h0, 32'd2};
    repeat (100) @(posedge CLK);
    #1;
    @(negedge CLK);
    n_tests++;
    if (unknown_count !== 16'd100) begin
      n_fail++;
      $display("FAIL sat_ramp: count=%h, expected 0064", unknown_count);
    end
    repeat (65437) @(posedge CLK);
    #1;
    pipe_enq__ENA = 0;
    @(negedge CLK);
    n_tests++;
    if (unknown_count !== 16'hFFFF || last_unknown_id !== 32'd2) begin
      n_fail++;
      $display("FAIL sat_top: count=%h last=%h, expected ffff 2", unknown_count, last_unknown_id);
    end
    @(posedge CLK); #1;
    send(32'd3, 32'h0, 32'h0);
    @(negedge CLK);
    n_tests++;
    if (unknown_count !== 16'hFFFF || last_unknown_id !== 32'd3) begin
      n_fail++;
      $display("FAIL sat_hold: count=%h last=%h, expected ffff 3", unknown_count, last_unknown_id);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    int d0 = n_deliv;
    time t0;
    do_reset();
    indication_heard__RDY = 1;
    t0 = $time;
    for (int i = 0; i < 100; i++) send(32'd1, i, $urandom);
    n_tests++;
    if ($time - t0 != 1000) begin
      n_fail++;
      $display("FAIL b2b_rate: 100 sends took %0t, expected 1000", $time - t0);
    end
    drain();
    n_tests++;
    if (n_deliv - d0 != 100) begin
      n_fail++;
      $display("FAIL b2b_count: delivered=%0d, expected 100", n_deliv - d0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    indication_heard__RDY = 0;
    for (int i = 0; i < 3; i++) send(32'd4 + i, 32'h0, 32'h0);
    send(32'd1, 32'hC1, 32'h11);
    send(32'd1, 32'hC2, 32'h22);
    @(negedge CLK);
    n_tests++;
    if (unknown_count !== 16'd3 || pipe_enq__RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_fill: count=%h enqRDY=%b, expected 3 0", unknown_count, pipe_enq__RDY);
    end
    @(posedge CLK); #1;
    RST = 1;
    indication_heard__RDY = 1;
    sb.delete();
    @(negedge CLK);
    n_tests++;
    if (pipe_enq__RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_rdy: enqRDY=%b in reset, expected 0", pipe_enq__RDY);
    end
    @(posedge CLK); #1;
    RST = 0;
    @(negedge CLK);
    n_tests++;
    if ({indication_heard__ENA, pipe_enq__RDY} !== 2'b01 || unknown_count !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_after: ENA=%b enqRDY=%b count=%h, expected 0 1 0",
               indication_heard__ENA, pipe_enq__RDY, unknown_count);
    end
    repeat (5) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1;
    pipe_enq__ENA = 0;
    pipe_enq_v = '0;
    indication_heard__RDY = 0;
    @(posedge CLK); #1;
    test_reset();
    test_single();
    test_backpressure();
    test_unknown();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
